// File: rtl/tdm_demux_14_if.sv
// Signal bundle between the TDM link receiver and its environment.
// The link side drives en/s/d; the receiver drives the rebuilt word, strobes and counters.
interface tdm_demux_14_if #(
  parameter int N_LANES = 4,
  parameter int SEL_W   = 2,
  parameter int ERR_W   = 8
);
  // Handshake: there is no back-pressure. A sample (s, d) is consumed on every
  // rising clk where en=1; o_valid and err are single-cycle pulses the consumer
  // must capture in the cycle they are high.
  logic               en;
  logic [SEL_W-1:0]   s;
  logic               d;
  logic [N_LANES-1:0] o;
  logic               o_valid;
  logic               sync;
  logic               err;
  logic [ERR_W-1:0]   err_cnt;
  logic               state_dbg;

  modport master (
    output en, s, d,
    input  o, o_valid, sync, err, err_cnt, state_dbg
  );

  modport slave (
    input  en, s, d,
    output o, o_valid, sync, err, err_cnt, state_dbg
  );
endinterface

// File: rtl/tdm_demux_14.sv
// Receive end of a 4:1 TDM link: rebuilds the parallel word from (s, d) samples,
// tracks frame sync and counts slot-sequence violations with a saturating counter.
module tdm_demux_14 #(
  parameter int N_LANES = 4,
  parameter int SEL_W   = 2,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  tdm_demux_14_if.slave    bus
);

  typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   exp_q, exp_d;
  logic [N_LANES-1:0] shadow_q, shadow_d;
  logic [N_LANES-1:0] o_q, o_d;
  logic               o_valid_q, o_valid_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      exp_q     <= '0;
      shadow_q  <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      shadow_q  <= shadow_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    shadow_d  = shadow_q;
    o_d       = o_q;
    o_valid_d = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (bus.en) begin
      unique case (state_q)
        HUNT: begin
          if (bus.s == '0) begin
            shadow_d[0] = bus.d;
            exp_d       = SEL_W'(1);
            state_d     = COLLECT;
          end
        end
        COLLECT: begin
          if (bus.s == exp_q) begin
            shadow_d[exp_q] = bus.d;
            if (exp_q == SEL_W'(N_LANES - 1)) begin
              // The last slot goes straight to o; the shadow copy is not needed.
              o_d       = {bus.d, shadow_q[N_LANES-2:0]};
              o_valid_d = 1'b1;
              exp_d     = '0;
            end else begin
              exp_d = exp_q + SEL_W'(1);
            end
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            // A stray slot 0 is taken as the start of a fresh frame rather than lost.
            if (bus.s == '0) begin
              shadow_d[0] = bus.d;
              exp_d       = SEL_W'(1);
            end else begin
              state_d = HUNT;
              exp_d   = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign bus.o         = o_q;
  assign bus.o_valid   = o_valid_q;
  assign bus.sync      = (state_q == COLLECT);
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.state_dbg = logic'(state_q);

endmodule

// File: tb/tb_tdm_demux_14.sv
// Directed bench for tdm_demux_14: vector table for the frame sequences,
// hand-written sequences for async reset and error-counter saturation.
module tb_tdm_demux_14;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  tdm_demux_14_if #(.N_LANES(4), .SEL_W(2), .ERR_W(8)) bus ();

  tdm_demux_14 #(.N_LANES(4), .SEL_W(2), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] s;
    logic       d;
    logic [3:0] exp_o;
    logic       exp_valid;
    logic       exp_sync;
    logic       exp_err;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic en, input logic [1:0] s, input logic d,
                         input logic [3:0] o, input logic v, input logic sy,
                         input logic e, input logic [7:0] c);
    vec_t r;
    r.en = en; r.s = s; r.d = d;
    r.exp_o = o; r.exp_valid = v; r.exp_sync = sy; r.exp_err = e; r.exp_cnt = c;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: apply one sample, clock it, settle 1 time unit past the edge
  task automatic step(input logic en, input logic [1:0] s, input logic d);
    bus.en = en;
    bus.s  = s;
    bus.d  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] o, input logic v,
                           input logic sy, input logic e, input logic [7:0] c);
    check({tag, " o"},       32'(bus.o),       32'(o));
    check({tag, " o_valid"}, 32'(bus.o_valid), 32'(v));
    check({tag, " sync"},    32'(bus.sync),    32'(sy));
    check({tag, " err"},     32'(bus.err),     32'(e));
    check({tag, " err_cnt"}, 32'(bus.err_cnt), 32'(c));
  endtask

  initial begin
    logic [7:0] m_cnt;
    n_cmp  = 0;
    n_fail = 0;
    bus.en = 1'b0;
    bus.s  = 2'd0;
    bus.d  = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
    check("reset state_dbg", 32'(bus.state_dbg), 32'd0);
    rst = 1'b0;

    // 1: clean frame 1010
    add_vec(1, 2'd0, 0, 4'b0000, 0, 1, 0, 8'd0);
    add_vec(1, 2'd1, 1, 4'b0000, 0, 1, 0, 8'd0);
    add_vec(1, 2'd2, 0, 4'b0000, 0, 1, 0, 8'd0);
    add_vec(1, 2'd3, 1, 4'b1010, 1, 1, 0, 8'd0);
    // 2: out-of-order slot 3 -> err, back to HUNT; slot 2 then ignored
    add_vec(1, 2'd0, 0, 4'b1010, 0, 1, 0, 8'd0);
    add_vec(1, 2'd1, 1, 4'b1010, 0, 1, 0, 8'd0);
    add_vec(1, 2'd3, 1, 4'b1010, 0, 0, 1, 8'd1);
    add_vec(1, 2'd2, 0, 4'b1010, 0, 0, 0, 8'd1);
    // 3: mid-frame start, i=0110
    add_vec(1, 2'd2, 1, 4'b1010, 0, 0, 0, 8'd1);
    add_vec(1, 2'd3, 0, 4'b1010, 0, 0, 0, 8'd1);
    add_vec(1, 2'd0, 0, 4'b1010, 0, 1, 0, 8'd1);
    add_vec(1, 2'd1, 1, 4'b1010, 0, 1, 0, 8'd1);
    add_vec(1, 2'd2, 1, 4'b1010, 0, 1, 0, 8'd1);
    add_vec(1, 2'd3, 0, 4'b0110, 1, 1, 0, 8'd1);
    // 4: i=1100 with 3-cycle en=0 gaps carrying misleading s/d
    add_vec(1, 2'd0, 0, 4'b0110, 0, 1, 0, 8'd1);
    for (int g = 0; g < 3; g++) add_vec(0, 2'd3, 1, 4'b0110, 0, 1, 0, 8'd1);
    add_vec(1, 2'd1, 0, 4'b0110, 0, 1, 0, 8'd1);
    for (int g = 0; g < 3; g++) add_vec(0, 2'd0, 1, 4'b0110, 0, 1, 0, 8'd1);
    add_vec(1, 2'd2, 1, 4'b0110, 0, 1, 0, 8'd1);
    for (int g = 0; g < 3; g++) add_vec(0, 2'd2, 0, 4'b0110, 0, 1, 0, 8'd1);
    add_vec(1, 2'd3, 1, 4'b1100, 1, 1, 0, 8'd1);
    add_vec(0, 2'd1, 0, 4'b1100, 0, 1, 0, 8'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].s, vecs[i].d);
      check_all($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].exp_valid,
                vecs[i].exp_sync, vecs[i].exp_err, vecs[i].exp_cnt);
    end

    // 5: async reset mid-frame (between edges), then frame 0011
    step(1, 2'd0, 1);
    step(1, 2'd1, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    step(1, 2'd0, 1);
    check("rst_f0 sync", 32'(bus.sync), 32'd1);
    step(1, 2'd1, 1);
    step(1, 2'd2, 0);
    step(1, 2'd3, 0);
    check_all("rst_frame", 4'b0011, 1'b1, 1'b1, 1'b0, 8'd0);

    // 6: 300 errors from alternating s=0,2; counter must saturate at 255
    m_cnt = 8'd0;
    for (int i = 0; i < 300; i++) begin
      step(1, 2'd0, 0);
      check($sformatf("sat%0d err0", i), 32'(bus.err), 32'd0);
      step(1, 2'd2, 0);
      if (m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
      check($sformatf("sat%0d err", i), 32'(bus.err), 32'd1);
      check($sformatf("sat%0d cnt", i), 32'(bus.err_cnt), 32'(m_cnt));
    end
    check("sat final cnt", 32'(bus.err_cnt), 32'd255);
    check("sat sync", 32'(bus.sync), 32'd0);
    step(1, 2'd0, 1);
    step(1, 2'd1, 1);
    step(1, 2'd2, 1);
    step(1, 2'd3, 1);
    check_all("after_sat", 4'b1111, 1'b1, 1'b1, 1'b0, 8'd255);
    step(0, 2'd0, 0);
    check("after_sat valid_drop", 32'(bus.o_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
